dda_irs_emulator: RTL and testbench
===================================

DDA_IRS_EMULATOR -- requirements
Module: dda_irs_emulator

Interface
REQ-001 SHALL have parameter NUM_CH, default 8: number of digitizer channels, 2..16, power of two.
REQ-002 SHALL have parameter NUM_SMP, default 64: samples per block, 4..256, power of two.
REQ-003 SHALL have parameter DAT_W, default 12: sample width in bits, 8..16.
REQ-004 SHALL have parameter BLK_W, default 9: block address width.
REQ-005 SHALL have parameter CONV_CYCLES, default 32: conversion duration in clocks, at least 2.
REQ-006 SHALL have the following ports; CW = clog2(NUM_CH) and SW = clog2(NUM_SMP).
- clk_i  in  1  sole clock; all logic on rising edge.
- rst_n_i  in  1  reset, synchronous, active-low.
- power_i  in  1  daughterboard SENSE, high = powered.
- capture_i  in  1  single-cycle request to digitize block blk_addr_i.
- blk_addr_i  in  BLK_W  block address to digitize.
- mode_i  in  2  pattern mode.
- ped_i  in  DAT_W  pedestal value.
- rd_addr_rst_i  in  1  level; rising edge zeroes the readout pointer.
- rd_addr_adv_i  in  1  level; rising edge advances the readout pointer.
- smpall_i  in  1  1 = address by readout pointer; 0 = address by smp_i.
- smp_i  in  SW  direct sample address.
- ch_i  in  CW  channel select.
- doe_i  in  1  data output enable.
- dat_o  out  DAT_W  sample data.
- busy_o  out  1  conversion in progress.
- ready_o  out  1  block converted and readable.
- wrap_o  out  1  sticky; readout pointer wrapped.
- ovf_o  out  1  sticky; capture rejected.

Function
REQ-007 SHALL implement FSM states IDLE, CONVERT, READY.
REQ-008 SHALL move IDLE->CONVERT and READY->CONVERT on capture_i=1 with power_i=1.
REQ-009 SHALL, on entering CONVERT, latch blk_addr_i, mode_i and ped_i, and clear the conversion counter, readout pointer and wrap_o.
REQ-010 SHALL hold CONVERT for exactly CONV_CYCLES clocks, then enter READY.
REQ-011 SHALL, on capture_i=1 while in CONVERT, ignore the request, set ovf_o, and leave the conversion unaffected.
REQ-012 SHALL force the FSM to IDLE within one clock of power_i=0, from any state; dat_o, busy_o and ready_o go to 0.
REQ-013 SHALL drive busy_o = (state==CONVERT) and ready_o = (state==READY), both registered.
REQ-014 SHALL edge-detect rd_addr_rst_i and rd_addr_adv_i against their one-cycle-delayed copies; they act only in READY.
REQ-015 SHALL make the readout pointer SW bits wide; an advance from NUM_SMP-1 wraps to 0 and sets wrap_o.
REQ-016 SHALL give reset priority over advance when both edges occur in the same cycle: pointer = 0, wrap_o unchanged.
REQ-017 SHALL compute sample address s as the pointer if smpall_i=1, else smp_i; c = ch_i.
REQ-018 SHALL generate the pattern value from latched mode and ped:
- mode 0: (ped + s) mod 2^DAT_W.
- mode 1: ped.
- mode 2: {c, s} zero-extended, or truncated to the low DAT_W bits.
- mode 3: ped XOR latched block address, block address zero-extended or truncated to DAT_W.
REQ-019 SHALL register dat_o: value = pattern when doe_i=1 and READY, else 0; latency exactly 1 clock from an address, ch_i or doe_i change.
REQ-020 SHALL reflect pointer updates in dat_o one clock after the pointer changes (2 clocks after the edge-detected strobe input).
REQ-021 SHALL clear ovf_o only on reset; wrap_o clears on reset or on entering CONVERT.

Reset
REQ-022 SHALL, with rst_n_i=0 at a clock edge, set: state IDLE; dat_o=0; busy_o=0; ready_o=0; wrap_o=0; ovf_o=0; pointer=0; counter=0; latched block/mode/ped=0; strobe delay registers=0.
REQ-023 SHALL give reset priority over every other input, including mid-CONVERT; no partial conversion completes afterwards.

Verification
REQ-024 SHALL cover capture blk=5, mode 0, ped=0x100 -> busy_o high exactly 32 clocks, then ready_o=1; smpall=0, smp=3, doe=1 -> dat_o=0x103 one clock later.
REQ-025 SHALL cover smpall=1, 64 adv edges from pointer 0 -> dat_o steps ped+0..ped+63 then back to ped+0; wrap_o=1 after the 64th edge.
REQ-026 SHALL cover mode 2, ch=5, smp=0x2A, DAT_W=12 -> dat_o=0x16A; doe=0 -> dat_o=0 next clock.
REQ-027 SHALL cover capture asserted at cycle 10 of CONVERT -> ovf_o=1, ready_o at the original cycle 32; a new capture from READY restarts and clears wrap_o.
REQ-028 SHALL cover simultaneous rst and adv edges at pointer 7 -> pointer 0; power_i=0 mid-CONVERT -> IDLE next clock, outputs 0.
REQ-029 SHALL cover rst_n_i=0 during READY with ovf_o=1 -> all outputs 0 next clock; rd strobes ignored until the next conversion completes.

Source files
------------

// File: rtl/dda_irs_emulator.sv
// Digitizer daughterboard (IRS) emulator: timed block conversion followed by
// pattern readout addressed by a strobe-driven pointer or a direct sample address.
module dda_irs_emulator #(
  parameter int NUM_CH      = 8,
  parameter int NUM_SMP     = 64,
  parameter int DAT_W       = 12,
  parameter int BLK_W       = 9,
  parameter int CONV_CYCLES = 32,
  localparam int CW         = $clog2(NUM_CH),
  localparam int SW         = $clog2(NUM_SMP)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             power_i,
  input  logic             capture_i,
  input  logic [BLK_W-1:0] blk_addr_i,
  input  logic [1:0]       mode_i,
  input  logic [DAT_W-1:0] ped_i,
  input  logic             rd_addr_rst_i,
  input  logic             rd_addr_adv_i,
  input  logic             smpall_i,
  input  logic [SW-1:0]    smp_i,
  input  logic [CW-1:0]    ch_i,
  input  logic             doe_i,
  output logic [DAT_W-1:0] dat_o,
  output logic             busy_o,
  output logic             ready_o,
  output logic             wrap_o,
  output logic             ovf_o
);

  // state   | meaning
  // IDLE    | no block held, waiting for capture
  // CONVERT | conversion running for CONV_CYCLES clocks
  // READY   | block converted, readout strobes and data enabled
  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_READY} state_t;

  localparam int CNT_W = (CONV_CYCLES > 2) ? $clog2(CONV_CYCLES) : 1;
  localparam int PW_A  = (DAT_W > CW + SW) ? DAT_W : CW + SW;
  localparam int PW    = (PW_A > BLK_W) ? PW_A : BLK_W;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]      ptr_q, ptr_d;
  logic [BLK_W-1:0]   blk_q, blk_d;
  logic [1:0]         mode_q, mode_d;
  logic [DAT_W-1:0]   ped_q, ped_d;
  logic               wrap_q, wrap_d;
  logic               ovf_q, ovf_d;
  logic               rst_dly_q, adv_dly_q;
  logic [DAT_W-1:0]   dat_q, dat_d;
  logic               busy_q, ready_q;

  logic               start, rd_rst_rise, rd_adv_rise;
  logic [SW-1:0]      s_addr;
  logic [PW-1:0]      cs_ext, blk_ext;
  logic [DAT_W-1:0]   pattern;

  assign start       = power_i && capture_i && (state_q != S_CONVERT);
  assign rd_rst_rise = rd_addr_rst_i && !rst_dly_q;
  assign rd_adv_rise = rd_addr_adv_i && !adv_dly_q;
  assign s_addr      = smpall_i ? ptr_q : smp_i;
  assign cs_ext      = PW'({ch_i, s_addr});
  assign blk_ext     = PW'(blk_q);

  always_comb begin
    pattern = ped_q;
    case (mode_q)
      2'd0:    pattern = ped_q + DAT_W'(s_addr);
      2'd1:    pattern = ped_q;
      2'd2:    pattern = cs_ext[DAT_W-1:0];
      default: pattern = ped_q ^ blk_ext[DAT_W-1:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    blk_d   = blk_q;
    mode_d  = mode_q;
    ped_d   = ped_q;
    wrap_d  = wrap_q;
    ovf_d   = ovf_q;

    if (power_i && capture_i && state_q == S_CONVERT) ovf_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CONVERT;
      end
      S_CONVERT: begin
        if (cnt_q == CNT_W'(CONV_CYCLES - 1)) state_d = S_READY;
        else                                  cnt_d   = cnt_q + 1'b1;
      end
      S_READY: begin
        if (start) begin
          state_d = S_CONVERT;
        end else if (rd_rst_rise) begin
          ptr_d = '0;
        end else if (rd_adv_rise) begin
          if (ptr_q == SW'(NUM_SMP - 1)) wrap_d = 1'b1;
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      cnt_d  = '0;
      ptr_d  = '0;
      wrap_d = 1'b0;
      blk_d  = blk_addr_i;
      mode_d = mode_i;
      ped_d  = ped_i;
    end

    // Losing SENSE overrides everything except reset.
    if (!power_i) state_d = S_IDLE;

    dat_d = (state_d == S_READY && doe_i) ? pattern : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      blk_q     <= '0;
      mode_q    <= '0;
      ped_q     <= '0;
      wrap_q    <= 1'b0;
      ovf_q     <= 1'b0;
      rst_dly_q <= 1'b0;
      adv_dly_q <= 1'b0;
      dat_q     <= '0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      blk_q     <= blk_d;
      mode_q    <= mode_d;
      ped_q     <= ped_d;
      wrap_q    <= wrap_d;
      ovf_q     <= ovf_d;
      rst_dly_q <= rd_addr_rst_i;
      adv_dly_q <= rd_addr_adv_i;
      dat_q     <= dat_d;
      busy_q    <= (state_d == S_CONVERT);
      ready_q   <= (state_d == S_READY);
    end
  end

  assign dat_o   = dat_q;
  assign busy_o  = busy_q;
  assign ready_o = ready_q;
  assign wrap_o  = wrap_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_dda_irs_emulator.sv
// Scoreboard bench for dda_irs_emulator: per-cycle expected outputs from a
// behavioural model, checked by an independent monitor at the falling edge.
module tb_dda_irs_emulator;
  localparam int NUM_CH = 8, NUM_SMP = 64, DAT_W = 12, BLK_W = 9, CONV_CYCLES = 32;
  localparam int CW = $clog2(NUM_CH), SW = $clog2(NUM_SMP);

  logic clk = 1'b0;
  logic rst_n = 1'b0, power = 1'b1, capture = 1'b0;
  logic [BLK_W-1:0] blk = '0;
  logic [1:0] mode = '0;
  logic [DAT_W-1:0] ped = '0;
  logic rd_rst = 1'b0, rd_adv = 1'b0, smpall = 1'b0, doe = 1'b0;
  logic [SW-1:0] smp = '0;
  logic [CW-1:0] ch = '0;
  logic [DAT_W-1:0] dat;
  logic busy, ready, wrap, ovf;

  dda_irs_emulator #(.NUM_CH(NUM_CH), .NUM_SMP(NUM_SMP), .DAT_W(DAT_W), .BLK_W(BLK_W),
                     .CONV_CYCLES(CONV_CYCLES)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .power_i(power), .capture_i(capture), .blk_addr_i(blk),
    .mode_i(mode), .ped_i(ped), .rd_addr_rst_i(rd_rst), .rd_addr_adv_i(rd_adv),
    .smpall_i(smpall), .smp_i(smp), .ch_i(ch), .doe_i(doe),
    .dat_o(dat), .busy_o(busy), .ready_o(ready), .wrap_o(wrap), .ovf_o(ovf));

  always #5 clk = ~clk;

  typedef struct {int dat; bit busy, ready, wrap, ovf;} exp_t;
  exp_t sb_q[$];
  int total = 0, bad = 0;

  // reference model: conversion as a remaining-clock count, pointer as an integer
  int m_left = 0, m_ptr = 0, m_blk = 0, m_mode = 0, m_ped = 0;
  bit m_ready = 0, m_wrap = 0, m_ovf = 0, m_rrst_p = 0, m_radv_p = 0;

  task automatic check(string nm, int act, int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic int pat(int md, int pd, int bk, int c, int s);
    case (md)
      0: return (pd + s) % (1 << DAT_W);
      1: return pd;
      2: return (c * NUM_SMP + s) % (1 << DAT_W);
      default: return pd ^ (bk % (1 << DAT_W));
    endcase
  endfunction

  // Evaluate the model for the inputs about to be sampled, queue the result, then clock.
  task automatic step();
    exp_t e;
    bit rr, ar, was_ready, start;
    int p;
    if (!rst_n) begin
      m_left = 0; m_ptr = 0; m_blk = 0; m_mode = 0; m_ped = 0;
      m_ready = 0; m_wrap = 0; m_ovf = 0; m_rrst_p = 0; m_radv_p = 0;
      p = 0;
    end else begin
      rr = rd_rst && !m_rrst_p;
      ar = rd_adv && !m_radv_p;
      m_rrst_p = rd_rst;
      m_radv_p = rd_adv;
      was_ready = m_ready;
      p = pat(m_mode, m_ped, m_blk, int'(ch), smpall ? m_ptr : int'(smp));
      start = power && capture && m_left == 0;
      if (power && capture && m_left > 0) m_ovf = 1;
      if (was_ready && !start) begin
        if (rr) m_ptr = 0;
        else if (ar) begin
          m_ptr = (m_ptr + 1) % NUM_SMP;
          if (m_ptr == 0) m_wrap = 1;
        end
      end
      if (!power) begin
        m_left = 0; m_ready = 0;
      end else if (start) begin
        m_left = CONV_CYCLES; m_ready = 0; m_ptr = 0; m_wrap = 0;
        m_blk = int'(blk); m_mode = int'(mode); m_ped = int'(ped);
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_ready = 1;
      end
    end
    e.dat = (m_ready && doe) ? p : 0;
    e.busy = m_left > 0;
    e.ready = m_ready;
    e.wrap = m_wrap;
    e.ovf = m_ovf;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sb_dat", int'(dat), e.dat);
        check("sb_busy", int'(busy), int'(e.busy));
        check("sb_ready", int'(ready), int'(e.ready));
        check("sb_wrap", int'(wrap), int'(e.wrap));
        check("sb_ovf", int'(ovf), int'(e.ovf));
      end
    end
  end

  task automatic steps(int n);
    repeat (n) step();
  endtask

  task automatic adv_pulse();
    rd_adv = 1; step();
    rd_adv = 0; step();
  endtask

  task automatic do_capture(int b, int md, int pd);
    blk = BLK_W'(b); mode = md[1:0]; ped = DAT_W'(pd);
    capture = 1; step();
    capture = 0;
  endtask

  initial begin : stim
    @(negedge clk);
    steps(3);
    check("rst_dat", int'(dat), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1; step();

    // timed conversion and direct-address readout
    do_capture(5, 0, 'h100);
    steps(CONV_CYCLES - 1);
    check("conv_busy_last", int'(busy), 1);
    check("conv_not_ready", int'(ready), 0);
    step();
    check("conv_ready", int'(ready), 1);
    check("conv_busy_off", int'(busy), 0);
    smpall = 0; smp = 3; doe = 1; step();
    check("dat_smp3", int'(dat), 'h103);

    // pointer walk through a full block
    smpall = 1; step();
    check("ptr0", int'(dat), 'h100);
    for (int i = 0; i < NUM_SMP; i++) begin
      adv_pulse();
      check("ptr_walk", int'(dat), 'h100 + ((i + 1) % NUM_SMP));
    end
    check("wrap_set", int'(wrap), 1);

    // channel/sample pattern and output enable
    do_capture(0, 2, 0);
    check("wrap_clear", int'(wrap), 0);
    steps(CONV_CYCLES);
    smpall = 0; ch = 5; smp = 'h2A; step();
    check("mode2", int'(dat), 'h16A);
    doe = 0; step();
    check("doe_off", int'(dat), 0);

    // capture during conversion is rejected without disturbing timing
    do_capture(3, 1, 'h55);
    steps(9);
    capture = 1; step(); capture = 0;
    check("ovf_set", int'(ovf), 1);
    steps(CONV_CYCLES - 11);
    check("ovf_busy", int'(busy), 1);
    step();
    check("ovf_ready", int'(ready), 1);

    // simultaneous pointer reset and advance, after a wrap
    do_capture(9, 0, 'h20);
    steps(CONV_CYCLES);
    doe = 1; smpall = 1;
    for (int i = 0; i < NUM_SMP + 7; i++) adv_pulse();
    check("ptr7", int'(dat), 'h27);
    rd_rst = 1; rd_adv = 1; step();
    rd_rst = 0; rd_adv = 0; step();
    check("rst_over_adv", int'(dat), 'h20);
    check("rst_keeps_wrap", int'(wrap), 1);

    // power loss mid-conversion
    do_capture(1, 0, 0);
    steps(5);
    power = 0; step();
    check("pwr_busy", int'(busy), 0);
    check("pwr_ready", int'(ready), 0);
    power = 1; steps(2);

    // reset during READY with overflow pending
    do_capture(2, 3, 'hABC);
    step();
    capture = 1; step(); capture = 0;
    steps(CONV_CYCLES - 2);
    check("pre_rst_ready", int'(ready), 1);
    check("pre_rst_ovf", int'(ovf), 1);
    rst_n = 0; step(); rst_n = 1;
    check("rst_ready", int'(ready), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_dat0", int'(dat), 0);
    adv_pulse(); rd_rst = 1; step(); rd_rst = 0; adv_pulse();
    check("strobe_ignored", int'(dat), 0);
    do_capture(2, 3, 'hABC);
    steps(CONV_CYCLES + 1);
    check("mode3", int'(dat), 'hABC ^ 2);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      power = ($urandom_range(0, 149) != 0);
      capture = ($urandom_range(0, 29) == 0);
      blk = BLK_W'($urandom);
      mode = 2'($urandom);
      ped = DAT_W'($urandom);
      rd_rst = ($urandom_range(0, 11) == 0);
      rd_adv = $urandom_range(0, 1) == 1;
      smpall = ($urandom_range(0, 3) != 0);
      smp = SW'($urandom);
      ch = CW'($urandom);
      doe = ($urandom_range(0, 7) != 0);
      step();
    end

    @(negedge clk);
    #1;
    check("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
